// File: rtl/demux4_onehot_pkg.sv
// ---------------------------------------------------------------------------
// demux4_onehot_pkg
//
// Shared definitions for the one-hot lane demultiplexer and its sibling
// 4:1 one-hot multiplexer in the counter datapath.
//
// Contents:
//   LANES      - number of output lanes (4)
//   RING_RST   - reset value of the round-robin ring select (lane 0)
//   is_onehot  - legality check for a LANES-wide one-hot select
//   lane_idx   - index of the set bit of a legal one-hot select
// ---------------------------------------------------------------------------
package demux4_onehot_pkg;

    localparam int LANES = 4;

    localparam logic [LANES-1:0] RING_RST = 4'b0001;

    // Exactly one bit set. All-zero and multi-hot selects are illegal.
    // Clearing the lowest set bit (v & (v-1)) leaves zero only when at most
    // one bit was set; the non-zero test rules out the empty select.
    function automatic logic is_onehot(input logic [LANES-1:0] v);
        logic [LANES-1:0] low_cleared;
        low_cleared = v & (v - 1'b1);
        return (v != '0) && (low_cleared == '0);
    endfunction

    // Position of the set bit. Only meaningful when is_onehot(v) holds;
    // for illegal selects the lowest set bit (or 0) is returned.
    function automatic logic [1:0] lane_idx(input logic [LANES-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux4_onehot_lane.sv
// ---------------------------------------------------------------------------
// demux_lane
//
// One output lane of the demultiplexer: a k-wide holding register and its
// valid flag.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset; clears data and valid
//   load   - write d into the lane on the next edge (upstream accepted a
//            word for this lane)
//   d      - incoming data word
//   ready  - downstream ready for this lane
//   data   - held word
//   valid  - lane holds a word not yet taken by downstream
//
// Handshake: a word leaves the lane on any rising edge where valid & ready
// are both high. A load on that same edge takes priority, so the lane stays
// valid with the new word and sustains one word per cycle.
// ---------------------------------------------------------------------------
module demux_lane #(
    parameter int k = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [k-1:0] d,
    input  logic         ready,
    output logic [k-1:0] data,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= d;
            valid <= 1'b1;
        end else if (valid && ready) begin
            // Drained: data is kept, only the flag drops.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux4_onehot.sv
// ---------------------------------------------------------------------------
// demux4_onehot
//
// Registered 1-to-4 demultiplexer with one-hot lane select. One input
// stream is steered into one of four lanes, each with a single-entry
// holding register. In auto mode an internal ring select walks the lanes
// 0,1,2,3,0,... advancing once per accepted word.
//
// Parameters:
//   k      - data width of the input and of each lane
//   ERR_W  - width of the saturating illegal-select counter
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   a               - input data word
//   in_valid        - input word present
//   in_ready        - input side can take a word this cycle (combinational)
//   s               - external one-hot lane select (ignored when auto=1)
//   auto            - 1: use ring select rr_sel, 0: use s
//   b0..b3          - lane holding registers
//   out_valid[i]    - lane i holds a word
//   out_ready[i]    - downstream of lane i takes the word this cycle
//   rr_sel          - current ring select, one-hot
//   err             - one-cycle pulse after an illegal select was consumed
//   err_cnt         - saturating count of consumed illegal selects
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high; valid never waits for ready. Input side: with a
// legal select, in_ready follows the target lane (empty, or draining this
// same edge). With an illegal select in_ready is forced high so the word is
// dropped rather than stalling the producer forever.
// ---------------------------------------------------------------------------
module demux4_onehot
    import demux4_onehot_pkg::*;
#(
    parameter int k     = 1,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [k-1:0]     a,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] s,
    input  logic             auto,
    output logic [k-1:0]     b0,
    output logic [k-1:0]     b1,
    output logic [k-1:0]     b2,
    output logic [k-1:0]     b3,
    output logic [LANES-1:0] out_valid,
    input  logic [LANES-1:0] out_ready,
    output logic [LANES-1:0] rr_sel,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [LANES-1:0] sel;
    logic             sel_legal;
    logic [LANES-1:0] lane_free;
    logic             acc;
    logic             acc_legal;
    logic             acc_illegal;
    logic [LANES-1:0] load;
    logic [k-1:0]     lane_data [LANES];

    // ---------------------------------------------------------------------
    // Select and input-side handshake
    // ---------------------------------------------------------------------
    always_comb begin
        sel       = auto ? rr_sel : s;
        sel_legal = is_onehot(sel);
        // A lane can take a word if it is empty or is being drained on the
        // same edge.
        lane_free = ~out_valid | out_ready;
        in_ready  = sel_legal ? |(sel & lane_free) : 1'b1;
    end

    always_comb begin
        acc         = in_valid & in_ready;
        acc_legal   = acc & sel_legal;
        acc_illegal = acc & ~sel_legal;
        load        = acc_legal ? sel : '0;
    end

    // ---------------------------------------------------------------------
    // Lanes
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        demux_lane #(
            .k (k)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .d     (a),
            .ready (out_ready[i]),
            .data  (lane_data[i]),
            .valid (out_valid[i])
        );
    end

    assign b0 = lane_data[0];
    assign b1 = lane_data[1];
    assign b2 = lane_data[2];
    assign b3 = lane_data[3];

    // ---------------------------------------------------------------------
    // Ring select: rotates left on each legal accept taken in auto mode.
    // Reset to a single set bit and only ever rotated, so it stays one-hot.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_sel <= RING_RST;
        end else if (acc_legal && auto) begin
            rr_sel <= {rr_sel[LANES-2:0], rr_sel[LANES-1]};
        end
    end

    // ---------------------------------------------------------------------
    // Illegal-select reporting
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= acc_illegal;
            if (acc_illegal && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux4_onehot.sv
// ---------------------------------------------------------------------------
// tb_demux4_onehot
//
// Two instances share all inputs: u_dut (ERR_W=8) and u_sat (ERR_W=2, to
// reach counter saturation quickly). A lane-level model tracks what each
// lane must hold; a compare process checks registered outputs after every
// rising edge and in_ready after every falling edge. Directed sequences add
// literal expectations, then a randomized phase runs against the model.
// ---------------------------------------------------------------------------
module tb_demux4_onehot;

    localparam int K = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // stimulus
    logic [K-1:0] a = '0;
    logic         in_valid = 1'b0;
    logic [3:0]   s = 4'b0000;
    logic         auto = 1'b0;
    logic [3:0]   out_ready = 4'b0000;

    // DUT outputs
    logic         in_ready, in_ready_s;
    logic [K-1:0] b0, b1, b2, b3, sb0, sb1, sb2, sb3;
    logic [3:0]   out_valid, out_valid_s, rr_sel, rr_sel_s;
    logic         err, err_s;
    logic [7:0]   err_cnt;
    logic [1:0]   err_cnt_s;

    demux4_onehot #(.k(K), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .auto(auto), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .out_valid(out_valid), .out_ready(out_ready), .rr_sel(rr_sel),
        .err(err), .err_cnt(err_cnt)
    );

    demux4_onehot #(.k(K), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .in_valid(in_valid), .in_ready(in_ready_s),
        .s(s), .auto(auto), .b0(sb0), .b1(sb1), .b2(sb2), .b3(sb3),
        .out_valid(out_valid_s), .out_ready(out_ready), .rr_sel(rr_sel_s),
        .err(err_s), .err_cnt(err_cnt_s)
    );

    logic [K-1:0] db [4];
    assign db[0] = b0;
    assign db[1] = b1;
    assign db[2] = b2;
    assign db[3] = b3;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: per-lane word + full flag, ring as a lane number.
    // -----------------------------------------------------------------------
    logic [K-1:0] m_b [4];
    logic         m_v [4];
    int           m_rr;
    logic         m_err;
    int           m_cnt8, m_cnt2;

    function automatic logic [3:0] m_sel();
        return auto ? (4'b0001 << m_rr) : s;
    endfunction

    function automatic bit m_legal(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int m_idx(input logic [3:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic m_in_ready();
        logic [3:0] v;
        v = m_sel();
        if (!m_legal(v)) return 1'b1;
        return !m_v[m_idx(v)] || out_ready[m_idx(v)];
    endfunction

    function automatic logic [3:0] m_valid_vec();
        return {m_v[3], m_v[2], m_v[1], m_v[0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0] v;
        bit         take;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_b[i] = '0;
                m_v[i] = 1'b0;
            end
            m_rr = 0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            v    = m_sel();
            take = in_valid && m_in_ready();
            m_err = 1'b0;
            for (int i = 0; i < 4; i++) if (m_v[i] && out_ready[i]) m_v[i] = 1'b0;
            if (take && m_legal(v)) begin
                m_b[m_idx(v)] = a;
                m_v[m_idx(v)] = 1'b1;
                if (auto) m_rr = (m_rr + 1) % 4;
            end else if (take) begin
                m_err  = 1'b1;
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Compare process
    // -----------------------------------------------------------------------
    always @(posedge clk or negedge clk) begin
        #2;
        if (clk) begin
            chk("b_vec", {b3, b2, b1, b0}, {m_b[3], m_b[2], m_b[1], m_b[0]});
            chk("b_vec_sat", {sb3, sb2, sb1, sb0}, {m_b[3], m_b[2], m_b[1], m_b[0]});
            chk("out_valid", out_valid, m_valid_vec());
            chk("out_valid_sat", out_valid_s, m_valid_vec());
            chk("rr_sel", rr_sel, 4'b0001 << m_rr);
            chk("rr_sel_sat", rr_sel_s, 4'b0001 << m_rr);
            chk("err", err, m_err);
            chk("err_sat", err_s, m_err);
            chk("err_cnt", err_cnt, m_cnt8);
            chk("err_cnt_sat", err_cnt_s, m_cnt2);
        end else begin
            chk("in_ready", in_ready, m_in_ready());
            chk("in_ready_sat", in_ready_s, m_in_ready());
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic cyc(input logic v, input logic [K-1:0] d, input logic [3:0] sl,
                       input logic au, input logic [3:0] ordy);
        @(negedge clk);
        in_valid  = v;
        a         = d;
        s         = sl;
        auto      = au;
        out_ready = ordy;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic [K-1:0] exp_q [$];
    int delivered;

    initial begin
        // reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_rr_sel", rr_sel, 4'b0001);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_b_vec", {b3, b2, b1, b0}, 0);
        #2 rst_n = 1'b1;

        // single word to lane 2, then backpressure
        cyc(1, 8'hA5, 4'b0100, 0, 4'b0000);
        after_edge();
        chk("lane2_valid", out_valid, 4'b0100);
        chk("lane2_data", b2, 8'hA5);
        cyc(1, 8'h5A, 4'b0100, 0, 4'b0000);
        #2 chk("lane2_stall_ready", in_ready, 1'b0);
        after_edge();
        chk("lane2_held", b2, 8'hA5);
        cyc(1, 8'h5A, 4'b0100, 0, 4'b0100);
        #2 chk("lane2_unstall_ready", in_ready, 1'b1);
        after_edge();
        chk("lane2_second", b2, 8'h5A);
        cyc(0, 8'h00, 4'b0100, 0, 4'b1111);
        after_edge();
        chk("lane2_drained", out_valid, 4'b0000);

        // 8 back-to-back words through lane 1
        for (int j = 1; j <= 8; j++) exp_q.push_back(K'(j));
        delivered = 0;
        for (int j = 1; j <= 8; j++) begin
            cyc(1, K'(j), 4'b0010, 0, 4'b0010);
            #2 chk("lane1_ready", in_ready, 1'b1);
            if (out_valid[1]) begin
                chk("lane1_deliver", b1, exp_q.pop_front());
                delivered++;
            end
            after_edge();
            chk("lane1_valid", out_valid[1], 1'b1);
            chk("lane1_data", b1, j);
        end
        cyc(0, 8'h00, 4'b0010, 0, 4'b0010);
        #2 if (out_valid[1]) begin
            chk("lane1_deliver", b1, exp_q.pop_front());
            delivered++;
        end
        after_edge();
        chk("lane1_idle", out_valid[1], 1'b0);
        chk("lane1_count", delivered, 8);
        chk("lane1_queue_empty", exp_q.size(), 0);

        // auto mode round robin
        for (int j = 0; j < 6; j++) begin
            cyc(1, K'(10 + j), 4'b0000, 1, 4'b1111);
            after_edge();
            chk("auto_data", db[j % 4], 10 + j);
            chk("auto_valid", out_valid[j % 4], 1'b1);
        end
        chk("auto_rr_end", rr_sel, 4'b0100);
        cyc(0, 8'h00, 4'b0000, 1, 4'b1111);
        cyc(0, 8'h00, 4'b0000, 1, 4'b1111);
        after_edge();
        chk("auto_rr_hold", rr_sel, 4'b0100);

        // illegal selects
        cyc(1, 8'h42, 4'b0001, 0, 4'b0000);
        after_edge();
        cyc(1, 8'hEE, 4'b0000, 0, 4'b0000);
        #2 chk("illegal_ready", in_ready, 1'b1);
        after_edge();
        chk("illegal_err1", err, 1'b1);
        chk("illegal_cnt1", err_cnt, 1);
        cyc(1, 8'hEE, 4'b0110, 0, 4'b0000);
        after_edge();
        chk("illegal_err2", err, 1'b1);
        chk("illegal_cnt2", err_cnt, 2);
        chk("illegal_lanes", out_valid, 4'b0001);
        cyc(0, 8'h00, 4'b0110, 0, 4'b0000);
        after_edge();
        chk("illegal_err_clear", err, 1'b0);
        for (int j = 0; j < 3; j++) cyc(1, 8'hEE, 4'b1111, 0, 4'b0000);
        after_edge();
        chk("sat_cnt8", err_cnt, 5);
        chk("sat_cnt2", err_cnt_s, 3);

        // asynchronous reset mid-cycle
        cyc(1, 8'h77, 4'b1000, 0, 4'b0000);
        after_edge();
        chk("pre_rst_valid", out_valid, 4'b1001);
        @(negedge clk);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 4'b0000);
        chk("async_rst_b", {b3, b2, b1, b0}, 0);
        chk("async_rst_rr", rr_sel, 4'b0001);
        chk("async_rst_cnt", err_cnt, 0);
        chk("async_rst_cnt_sat", err_cnt_s, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;

        // simultaneous drain and load on lane 2
        cyc(1, 8'h11, 4'b0100, 0, 4'b0000);
        after_edge();
        cyc(1, 8'h3C, 4'b0100, 0, 4'b0100);
        #2 chk("simul_ready", in_ready, 1'b1);
        after_edge();
        chk("simul_data", b2, 8'h3C);
        chk("simul_valid", out_valid, 4'b0100);

        // randomized phase
        for (int n = 0; n < 600; n++) begin
            logic [3:0] rs;
            logic       ra;
            if ($urandom_range(0, 9) < 7) rs = 4'b0001 << $urandom_range(0, 3);
            else rs = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) == 0) ? ~auto : auto;
            cyc($urandom_range(0, 3) != 0, K'($urandom_range(0, 255)), rs, ra,
                4'($urandom_range(0, 15)));
        end
        cyc(0, 8'h00, 4'b0000, 0, 4'b1111);
        after_edge();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux4_onehot.md
Name: demux4_onehot

Overview:
- Registered 1-to-4 demultiplexer with one-hot lane select; the distribution-side counterpart of the 4:1 one-hot multiplexer used in the counter datapath.
- Routes one input stream of width k to one of four output lanes.
- Each lane has a valid/ready handshake and a 1-entry holding register.
- An auto mode uses an internal ring counter to walk lanes 0→1→2→3→0, so an upstream producer can spread work without generating selects.

Parameters:
k, 1, data width of input and each output lane
ERR_W, 8, width of saturating illegal-select counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
a  input  k  input data
in_valid  input  1  input data valid
in_ready  output  1  input accepted this cycle when in_valid&in_ready
s  input  4  one-hot lane select (bit i = lane i); ignored when auto=1
auto  input  1  1 = use internal ring select, 0 = use s
b0,b1,b2,b3  output  k each  lane data registers
out_valid  output  4  per-lane valid, bit i for lane i
out_ready  input  4  per-lane ready, bit i for lane i
rr_sel  output  4  current ring-counter select (one-hot)
err  output  1  one-cycle pulse: illegal select was consumed
err_cnt  output  ERR_W  saturating count of illegal selects

Behaviour:
- Reset (rst_n=0, asynchronous): b0..b3=0, out_valid=4'b0000, rr_sel=4'b0001, err=0, err_cnt=0. Takes effect immediately, mid-transfer included. Held lane data is discarded.
- Effective select: sel = auto ? rr_sel : s. Legal iff exactly one bit set; 0000 and multi-hot are illegal.
- in_ready (combinational):
  - Legal sel, lane i: in_ready = ~out_valid[i] | out_ready[i].
  - Illegal sel: in_ready = 1, so the input is drained rather than deadlocking.
- Accept: acc = in_valid & in_ready.
- Legal accept to lane i:
  - bi <= a and out_valid[i] <= 1 on the next edge; latency is 1 cycle.
  - Other lanes are unaffected.
- Lane drain: when out_valid[i] & out_ready[i] and lane i is not loaded this cycle, out_valid[i] <= 0. bi holds its last value.
- Simultaneous drain and load on the same lane: the new data replaces the old and out_valid[i] stays 1, giving full throughput of 1 word/cycle per lane.
- Lanes drain independently; all four may be valid at once.
- Illegal accept:
  - Data is dropped and no lane changes.
  - err <= 1 for exactly one cycle.
  - err_cnt <= err_cnt+1, saturating at 2^ERR_W-1 with no wrap.
- err is 0 in every cycle without an illegal accept.
- Ring counter:
  - Rotates left (0001→0010→0100→1000→0001) only on a legal accept while auto=1.
  - Holds while auto=0 and while stalled.
  - Stays one-hot by construction.
- in_valid=0: no state change except lane drains.
- out_ready has no effect on a lane whose out_valid=0.
- Changing auto between cycles is permitted; it takes effect on the next cycle's sel.
- Combinational paths: out_ready→in_ready and s/auto→in_ready. There is no path from a to any output.

Decomposition:
- Shared package: lane count constant (4), ring reset value 4'b0001, and a one-hot legality check function reusable by the 4:1 mux.
- One natural sub-module: demux_lane (k-wide holding register plus valid flag with load/drain logic), instantiated 4 times.

Test Plan:
- Reset then auto=0, s=0100, a=8'hA5, in_valid=1 for one cycle, out_ready=0 → next cycle out_valid=0100, b2=A5. A second word to lane 2 sees in_ready=0 until out_ready[2]=1.
- Lane 1 held with out_ready[1]=1 continuously, 8 back-to-back words 1..8 to s=0010 → in_ready stays 1, b1 follows with 1-cycle latency, out_valid[1] stays 1, no word lost or duplicated.
- auto=1, out_ready=1111, 6 consecutive words 10..15 → lanes 0,1,2,3,0,1 receive 10..15 in order; rr_sel ends at 0100. With in_valid=0 rr_sel holds.
- s=0000 then s=0110 with in_valid=1 → in_ready=1, err pulses each cycle, err_cnt=2, out_valid unchanged. With ERR_W=2 and 5 illegal words, err_cnt saturates at 3.
- Lane 3 loaded and lane 0 loaded, out_ready=0; assert rst_n=0 mid-cycle → out_valid=0000, b0..b3=0, rr_sel=0001, err_cnt=0 immediately, without waiting for a clock edge.
- Simultaneous: lane 2 valid, out_ready[2]=1, new word 8'h3C to s=0100 in the same cycle → b2=3C next cycle, out_valid[2]=1 with no bubble.
